// File: rtl/sync_fifo_if.sv
// Write/read request and status bundle for sync_fifo.
// master drives requests and write data; slave is the FIFO side.
interface sync_fifo_if #(
    parameter int fifo_width = 8
);
    logic                  fifo_write;
    logic [fifo_width-1:0] fifo_data_in;
    logic                  fifo_read;
    logic [fifo_width-1:0] fifo_data_out;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_almost_full;
    logic                  fifo_almost_empty;
    logic                  fifo_overflow;
    logic                  fifo_underflow;

    modport master (
        output fifo_write, fifo_data_in, fifo_read,
        input  fifo_data_out, fifo_full, fifo_empty, fifo_almost_full,
               fifo_almost_empty, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  fifo_write, fifo_data_in, fifo_read,
        output fifo_data_out, fifo_full, fifo_empty, fifo_almost_full,
               fifo_almost_empty, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-decoded status and sticky overflow/underflow flags.
// Latency: registered read data appears one clock after an accepted read.
// Backpressure: writes to a full FIFO are dropped unless a read frees the slot that same cycle.
module sync_fifo #(
    parameter int fifo_depth      = 8,
    parameter int fifo_width      = 8,
    parameter int almost_full_th  = 6,
    parameter int almost_empty_th = 2
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave fif
);
    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(fifo_depth);
    localparam logic [AW:0] AF_TH   = (AW+1)'(almost_full_th);
    localparam logic [AW:0] AE_TH   = (AW+1)'(almost_empty_th);

    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW:0]           cnt;
    logic [fifo_width-1:0] mem [fifo_depth];
    logic [fifo_width-1:0] data_out_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
    assign wr_ok = fif.fifo_write && (!fif.fifo_full || fif.fifo_read);
    assign rd_ok = fif.fifo_read && !fif.fifo_empty;

    assign fif.fifo_full         = (cnt == DEPTH_C);
    assign fif.fifo_empty        = (cnt == '0);
    assign fif.fifo_almost_full  = (cnt >= AF_TH);
    assign fif.fifo_almost_empty = (cnt <= AE_TH);
    assign fif.fifo_data_out     = data_out_q;
    assign fif.fifo_overflow     = overflow_q;
    assign fif.fifo_underflow    = underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                data_out_q <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok)
                cnt <= cnt + (AW+1)'(1);
            else if (rd_ok && !wr_ok)
                cnt <= cnt - (AW+1)'(1);
            if (fif.fifo_write && !wr_ok)
                overflow_q <= 1'b1;
            if (fif.fifo_read && !rd_ok)
                underflow_q <= 1'b1;
        end
    end

    // Storage is not reset; on a full read+write the old entry is read before this update lands.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_ptr] <= fif.fifo_data_in;
    end
endmodule
